led_shift_register: RTL and testbench

Serial-in, parallel-out shift register that drives a bank of LEDs.
- On every rising edge of clk, one bit is sampled from i_val and shifted into the LSB.
- All bits move one position toward the MSB, and the previous MSB is discarded.
- Sits between a slow serial source (switch/button or upstream logic) and the board LED pins; o_led drives the LEDs directly.

---
 rtl/led_shift_register_pkg.sv | 8 +
 rtl/led_shift_register_if.sv | 21 ++
 rtl/led_shift_register_sync.sv | 35 +++
 rtl/led_shift_register.sv | 54 +++++
 tb/tb_led_shift_register.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/led_shift_register_pkg.sv
// Shared constants for the LED shift register slice: default bank width and
// the deepest synchroniser the block will build.
package led_shift_register_pkg;

  localparam int unsigned LSR_DEFAULT_WIDTH = 10;
  localparam int unsigned LSR_SYNC_MAX      = 3;

endpackage : led_shift_register_pkg

// File: rtl/led_shift_register_if.sv
// Serial-in / parallel-out bundle between a bit source and the LED register.
import led_shift_register_pkg::*;

interface led_shift_register_if #(
  parameter int unsigned WIDTH = LSR_DEFAULT_WIDTH
);

  logic             i_val;
  logic [WIDTH-1:0] o_led;

  modport master (
    output i_val,
    input  o_led
  );

  modport slave (
    input  i_val,
    output o_led
  );

endinterface : led_shift_register_if

// File: rtl/led_shift_register_sync.sv
// Multi-flop bit synchroniser with synchronous active-high clear; reusable for
// any slow asynchronous button or switch input.
module led_shift_register_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Next-state of the flop chain: new bit enters stage 0, others move up.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < int'(STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : led_shift_register_sync

// File: rtl/led_shift_register.sv
// Serial-in, parallel-out shift register driving an LED bank; optional input
// synchroniser in front of the shift chain.
import led_shift_register_pkg::*;

module led_shift_register #(
  parameter int unsigned    WIDTH       = LSR_DEFAULT_WIDTH,
  parameter int unsigned    SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 resetn,
  led_shift_register_if.slave  bus
);

  // Depths beyond the supported maximum are clamped rather than built.
  localparam int unsigned STAGES_C =
    (SYNC_STAGES > LSR_SYNC_MAX) ? LSR_SYNC_MAX : SYNC_STAGES;

  logic             in_s;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shift_q;

  generate
    if (STAGES_C > 0) begin : g_sync
      led_shift_register_sync #(
        .STAGES (STAGES_C)
      ) u_sync (
        .clk   (clk),
        .rst_i (resetn),
        .d_i   (bus.i_val),
        .q_o   (in_s)
      );
    end else begin : g_direct
      assign in_s = bus.i_val;
    end
  endgenerate

  // Shift toward the MSB; the old MSB falls off, no rotate.
  always_comb begin
    shift_d = {shift_q[WIDTH-2:0], in_s};
  end

  // Register bank; the active-high resetn wins over shifting.
  always_ff @(posedge clk) begin
    if (resetn) begin
      shift_q <= RESET_VAL;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bus.o_led = shift_q;

endmodule : led_shift_register

// File: tb/tb_led_shift_register.sv
// Directed bench for led_shift_register: direct-sample and 2-stage synchronised
// instances sharing clock and reset.
module tb_led_shift_register;

  logic clk = 1'b0;
  logic resetn;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  led_shift_register_if #(.WIDTH(10)) bus0 ();
  led_shift_register_if #(.WIDTH(10)) bus2 ();

  led_shift_register #(.WIDTH(10), .SYNC_STAGES(0)) dut0 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  led_shift_register #(.WIDTH(10), .SYNC_STAGES(2)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%03h expected=0x%03h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b1;
    bus0.i_val = 1'b1;
    bus2.i_val = 1'b1;
    tick();
    resetn     = 1'b0;
    bus0.i_val = 1'b0;
    bus2.i_val = 1'b0;
  endtask

  logic [9:0] exp_v;
  logic [6:0] pat;
  logic [9:0] pat155;
  logic [9:0] vec2 [7];

  initial begin
    resetn     = 1'b0;
    bus0.i_val = 1'b0;
    bus2.i_val = 1'b0;
    vec2 = '{10'h001, 10'h002, 10'h004, 10'h009, 10'h013, 10'h026, 10'h04C};
    pat  = 7'b1001100;
    @(negedge clk);

    // 1: reset ignores i_val=1, then zeros hold
    do_reset();
    check_val("reset", bus0.o_led, 10'h000);
    check_val("reset_sync", bus2.o_led, 10'h000);
    tick();
    check_val("hold0_a", bus0.o_led, 10'h000);
    tick();
    check_val("hold0_b", bus0.o_led, 10'h000);

    // 2: pattern 1,0,0,1,1,0,0
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus0.i_val = pat[6-i];
      tick();
      check_val($sformatf("pat_%0d", i), bus0.o_led, vec2[i]);
    end

    // 3: walking one falls off the MSB
    do_reset();
    bus0.i_val = 1'b1;
    tick();
    bus0.i_val = 1'b0;
    check_val("walk_0", bus0.o_led, 10'h001);
    exp_v = 10'h001;
    for (int i = 1; i < 10; i++) begin
      tick();
      exp_v = exp_v << 1;
      check_val($sformatf("walk_%0d", i), bus0.o_led, exp_v);
    end
    tick();
    check_val("walk_off", bus0.o_led, 10'h000);

    // 4: ones fill and persist
    do_reset();
    bus0.i_val = 1'b1;
    exp_v = 10'h000;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = {exp_v[8:0], 1'b1};
      check_val($sformatf("fill_%0d", i), bus0.o_led, exp_v);
    end
    check_val("fill_final", bus0.o_led, 10'h3FF);

    // 5: reset mid-stream from 0x155
    do_reset();
    pat155 = 10'h155;
    for (int i = 9; i >= 0; i--) begin
      bus0.i_val = pat155[i];
      tick();
    end
    check_val("load_155", bus0.o_led, 10'h155);
    do_reset();
    check_val("mid_reset", bus0.o_led, 10'h000);
    bus0.i_val = 1'b1;
    tick();
    check_val("after_reset", bus0.o_led, 10'h001);

    // 6: two-stage synchroniser latency and glitch immunity
    do_reset();
    bus0.i_val = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_val("sync_idle", bus2.o_led, 10'h000);
    bus2.i_val = 1'b1;
    tick();
    check_val("sync_n", bus2.o_led, 10'h000);
    tick();
    check_val("sync_n1", bus2.o_led, 10'h000);
    tick();
    check_val("sync_n2", bus2.o_led, 10'h001);
    bus2.i_val = 1'b0;
    tick();
    check_val("sync_n3", bus2.o_led, 10'h003);
    tick();
    check_val("sync_n4", bus2.o_led, 10'h007);
    tick();
    check_val("sync_n5", bus2.o_led, 10'h00E);
    #2;
    bus0.i_val = 1'b1;
    bus2.i_val = 1'b1;
    #2;
    bus0.i_val = 1'b0;
    bus2.i_val = 1'b0;
    tick();
    check_val("glitch_direct", bus0.o_led, 10'h000);
    tick();
    tick();
    check_val("glitch_sync", bus2.o_led, 10'h070);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_led_shift_register
